// File: rtl/pc_sequencer.sv
// Fetch PC register and next-PC selection for the 5-stage pipeline.
// A redirect that arrives during a stall is latched and applied when the stall drops.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] id_pcadd4,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pcadd4,
  output logic        flush,
  output logic        redirect_pending,
  output logic        align_err
);

  typedef enum logic {RUN, PEND} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        align_q, align_d;

  logic [31:0] br_tgt, j_tgt, sel_tgt;
  logic        req;

  assign br_tgt  = id_pcadd4 + {{14{br_offset[15]}}, br_offset, 2'b00};
  assign j_tgt   = {id_pcadd4[31:28], jump_index, 2'b00};
  assign sel_tgt = jr ? jr_target : (jump ? j_tgt : br_tgt);
  assign req     = jr | jump | br_taken;
  assign pcadd4  = pc_q + 32'd4;

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pend_d           = pend_q;
    align_d          = 1'b0;
    flush            = 1'b0;
    redirect_pending = 1'b0;
    case (state_q)
      RUN: begin
        if (!stall) begin
          if (req) begin
            pc_d    = sel_tgt;
            flush   = 1'b1;
            align_d = |sel_tgt[1:0];
          end else begin
            pc_d = pcadd4;
          end
        end else if (req) begin
          pend_d  = sel_tgt;
          state_d = PEND;
        end
      end
      PEND: begin
        // ID is frozen, so live request inputs are the already-latched one
        redirect_pending = 1'b1;
        if (!stall) begin
          pc_d    = pend_q;
          flush   = 1'b1;
          align_d = |pend_q[1:0];
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      flush            = 1'b0;
      redirect_pending = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= 32'd0;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      align_q <= align_d;
    end
  end

  assign pc        = pc_q;
  assign align_err = align_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer: one table row per clock cycle,
// outputs checked mid-cycle against hand-computed values.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, jump, jr;
  logic [31:0] id_pcadd4, jr_target;
  logic [15:0] br_offset;
  logic [25:0] jump_index;
  logic [31:0] pc, pcadd4;
  logic        flush, redirect_pending, align_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .id_pcadd4(id_pcadd4),
    .br_taken(br_taken), .br_offset(br_offset), .jump(jump),
    .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
    .pc(pc), .pcadd4(pcadd4), .flush(flush),
    .redirect_pending(redirect_pending), .align_err(align_err)
  );

  typedef struct {
    logic        rst, stall, br, jmp, jr;
    logic [31:0] idpc, jrt;
    logic [15:0] off;
    logic [25:0] idx;
    logic [31:0] e_pc;
    logic        e_fl, e_pend, e_al;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic s, logic b, logic j, logic jrr,
                              logic [31:0] idpc, logic [15:0] off, logic [25:0] idx,
                              logic [31:0] jrt, logic [31:0] epc,
                              logic efl, logic epend, logic eal);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.jmp = j; v.jr = jrr;
    v.idpc = idpc; v.off = off; v.idx = idx; v.jrt = jrt;
    v.e_pc = epc; v.e_fl = efl; v.e_pend = epend; v.e_al = eal;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; stall = v.stall; br_taken = v.br; jump = v.jmp; jr = v.jr;
    id_pcadd4 = v.idpc; br_offset = v.off; jump_index = v.idx; jr_target = v.jrt;
  endtask

  task automatic check_row(input int n, input vec_t v);
    chk($sformatf("row%0d pc", n), pc, v.e_pc);
    chk($sformatf("row%0d pcadd4", n), pcadd4, v.e_pc + 32'd4);
    chk($sformatf("row%0d flush", n), {31'd0, flush}, {31'd0, v.e_fl});
    chk($sformatf("row%0d pend", n), {31'd0, redirect_pending}, {31'd0, v.e_pend});
    chk($sformatf("row%0d align", n), {31'd0, align_err}, {31'd0, v.e_al});
  endtask

  initial begin
    //            rst s  br j  jr idpc          off       idx        jrt           exp pc       fl pd al
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_0004, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_0008, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_000C, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h10,       16'hFFFE, 26'h0,     32'h0,        32'h0000_0010, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h10,       16'h0003, 26'h0,     32'h0,        32'h0000_0008, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_001C, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'hA000_0104,16'h0,    26'h40,    32'h0,        32'h0000_0020, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 32'hA000_0104,16'h0003, 26'h40,    32'h0,        32'hA000_0100, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'hA000_0100, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h0,        16'h0,    26'h0,     32'h2000,     32'hA000_0104, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 32'h10,       16'h0003, 26'h0,     32'h2000,     32'hA000_0104, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 32'h10,       16'h0003, 26'h0,     32'h0,        32'hA000_0104, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h10,       16'h0003, 26'h0,     32'h0,        32'hA000_0104, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_2000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,     32'h1002,     32'h0000_2004, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_1002, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_1006, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_100A, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_100A, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_100A, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_100A, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_100E, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h0,     32'hFFFF_FFFC,32'h0000_1012, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'hFFFF_FFFC, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h0,        16'h0,    26'h0,     32'h4000,     32'h0000_0004, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h0,        16'h0,    26'h0,     32'h4000,     32'h0000_0004, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h0,        16'h0,    26'h0,     32'h4000,     32'h0000_0004, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_0004, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_0008, 0, 0, 0));
    // misaligned JR latched during a stall: align pulse follows the release
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h0,        16'h0,    26'h0,     32'h3001,     32'h0000_000C, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 32'h0,        16'h0,    26'h40,    32'h0,        32'h0000_000C, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'h0,        16'h0,    26'h40,    32'h0,        32'h0000_000C, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_3001, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,     32'h0,        32'h0000_3005, 0, 0, 0));

    drive(mk(1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset pc", pc, 32'h0);
    chk("reset flush", {31'd0, flush}, 32'd0);
    chk("reset pend", {31'd0, redirect_pending}, 32'd0);
    chk("reset align", {31'd0, align_err}, 32'd0);

    // reset asserted with a request present must still show no flush
    jr = 1'b1; jr_target = 32'h5000;
    #1;
    chk("reset req flush", {31'd0, flush}, 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i]);
      @(negedge clk);
      check_row(i, tbl[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
